// File: rtl/disp_seq_ctrl_pkg.sv
// rtl/disp_seq_ctrl_pkg.sv - display-select codes, sequencer state type and timer sizing
package disp_seq_ctrl_pkg;

    localparam logic [2:0] DISP_DASH   = 3'b000;
    localparam logic [2:0] DISP_MODE   = 3'b001;
    localparam logic [2:0] DISP_SCRAM  = 3'b010;
    localparam logic [2:0] DISP_RSCORE = 3'b011;
    localparam logic [2:0] DISP_TOTAL  = 3'b100;
    localparam logic [2:0] DISP_LAST   = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MODE,
        S_WAIT_WORD,
        S_PLAY,
        S_RSCORE,
        S_FINAL
    } seq_state_t;

    // One shared timer serves every counting state, so it is sized for the longest period.
    function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/disp_seq_ctrl_seq_timer.sv
// rtl/disp_seq_ctrl_seq_timer.sv - loadable up-counter with clear, enable and terminal-count compare
module seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == i_tc_val);

    // Parks on the terminal count so the count never runs past the compare value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/disp_seq_ctrl.sv
// rtl/disp_seq_ctrl.sv - game-flow sequencer driving the six-digit display mux select code
// Optional round timeout in PLAY enabled by defining ROUND_TIMEOUT_EN.
module disp_seq_ctrl
    import disp_seq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS   = 5,
    parameter int unsigned HOLD_CYCLES  = 50000000,
    parameter int unsigned BLINK_CYCLES = 25000000,
    parameter int unsigned PLAY_CYCLES  = 1500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_mode_confirm,
    input  logic       i_word_ready,
    input  logic       i_submit,
    output logic [2:0] o_ctrl_sig,
    output logic       o_word_req,
    output logic       o_score_latch,
    output logic [2:0] o_round_idx,
    output logic       o_game_done
);

    localparam int unsigned TW = tmr_width(HOLD_CYCLES, BLINK_CYCLES, PLAY_CYCLES);

    seq_state_t r_state;
    logic [2:0] r_ctrl_sig;
    logic [2:0] r_round_idx;
    logic       r_word_req;
    logic       r_score_latch;
    logic       r_game_done;

    logic          w_counting;
    logic [TW-1:0] w_tc_val;
    logic          w_tc;
    logic          w_timeout;
    logic          w_play_done;
    logic          w_tmr_clr;

    always_comb begin
        w_counting = 1'b0;
        w_tc_val   = TW'(HOLD_CYCLES - 1);
        case (r_state)
            S_RSCORE: w_counting = 1'b1;
            S_FINAL: begin
                w_counting = 1'b1;
                w_tc_val   = TW'(BLINK_CYCLES - 1);
            end
`ifdef ROUND_TIMEOUT_EN
            S_PLAY: begin
                w_counting = 1'b1;
                w_tc_val   = TW'(PLAY_CYCLES - 1);
            end
`endif
            default: w_counting = 1'b0;
        endcase
    end

`ifdef ROUND_TIMEOUT_EN
    assign w_timeout = (r_state == S_PLAY) && w_tc;
`else
    assign w_timeout = 1'b0;
`endif

    // Submit coinciding with timeout collapses into one round-end event.
    assign w_play_done = (r_state == S_PLAY) && (i_submit || w_timeout);
    assign w_tmr_clr   = i_start || !w_counting || w_tc || w_play_done;

    seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_tmr_clr),
        .i_en       (w_counting),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_tc_val   (w_tc_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ctrl_sig    <= DISP_DASH;
            r_round_idx   <= 3'd0;
            r_word_req    <= 1'b0;
            r_score_latch <= 1'b0;
            r_game_done   <= 1'b0;
        end else begin
            r_word_req    <= 1'b0;
            r_score_latch <= 1'b0;
            if (i_start) begin
                r_state     <= S_MODE;
                r_ctrl_sig  <= DISP_MODE;
                r_round_idx <= 3'd0;
                r_game_done <= 1'b0;
            end else begin
                case (r_state)
                    S_MODE: if (i_mode_confirm) begin
                        r_state    <= S_WAIT_WORD;
                        r_ctrl_sig <= DISP_DASH;
                        r_word_req <= 1'b1;
                    end
                    S_WAIT_WORD: if (i_word_ready) begin
                        r_state    <= S_PLAY;
                        r_ctrl_sig <= DISP_SCRAM;
                    end
                    S_PLAY: if (w_play_done) begin
                        r_state       <= S_RSCORE;
                        r_ctrl_sig    <= DISP_RSCORE;
                        r_score_latch <= 1'b1;
                    end
                    S_RSCORE: if (w_tc) begin
                        if (r_round_idx == 3'(NUM_ROUNDS - 1)) begin
                            r_state     <= S_FINAL;
                            r_ctrl_sig  <= DISP_TOTAL;
                            r_game_done <= 1'b1;
                        end else begin
                            r_state     <= S_WAIT_WORD;
                            r_ctrl_sig  <= DISP_DASH;
                            r_round_idx <= r_round_idx + 3'd1;
                            r_word_req  <= 1'b1;
                        end
                    end
                    S_FINAL: if (w_tc) begin
                        r_ctrl_sig <= (r_ctrl_sig == DISP_TOTAL) ? DISP_LAST : DISP_TOTAL;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign o_ctrl_sig    = r_ctrl_sig;
    assign o_word_req    = r_word_req;
    assign o_score_latch = r_score_latch;
    assign o_round_idx   = r_round_idx;
    assign o_game_done   = r_game_done;

endmodule
